// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one external 8-bit ALU between two requesters.
// Define ALU_ARB_STATS_EN to add saturating grant/conflict counters.
module alu_rr_arbiter #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned RST_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [2:0]        req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,
   output logic              rsp0_carry,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [2:0]        req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,
   output logic              rsp1_carry,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_carry,
   output logic              busy
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]       grant0_cnt,
   output logic [15:0]       grant1_cnt,
   output logic [15:0]       conflict_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;
   logic   ptr;
   logic   gnt;
   logic   win;
   logic   hs;

   // Winner selection and ready generation; ready only ever asserted in IDLE
   always_comb begin
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      hs         = 1'b0;
      win        = (req0_valid && req1_valid) ? ptr : req1_valid;
      case (state)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               req0_ready = !win;
               req1_ready = win;
               hs         = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC:    state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= 1'(RST_PRIO);
         gnt         <= 1'b0;
         busy        <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         rsp0_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp0_zero   <= 1'b0;
         rsp0_carry  <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp1_result <= '0;
         rsp1_zero   <= 1'b0;
         rsp1_carry  <= 1'b0;
      end else begin
         state      <= state_next;
         busy       <= (state_next != IDLE);
         rsp0_valid <= (state == EXEC) && !gnt;
         rsp1_valid <= (state == EXEC) && gnt;
         if (hs) begin
            alu_op <= win ? req1_op : req0_op;
            alu_a  <= win ? req1_a  : req0_a;
            alu_b  <= win ? req1_b  : req0_b;
            gnt    <= win;
            ptr    <= !win;
         end
         // ALU result is settled by the end of EXEC; only the granted side updates
         if (state == EXEC) begin
            if (gnt) begin
               rsp1_result <= alu_result;
               rsp1_zero   <= alu_zero;
               rsp1_carry  <= alu_carry;
            end else begin
               rsp0_result <= alu_result;
               rsp0_zero   <= alu_zero;
               rsp0_carry  <= alu_carry;
            end
         end
      end
   end

`ifdef ALU_ARB_STATS_EN
   localparam int unsigned CNT_W = 16;

   // Saturating handshake and conflict counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant0_cnt   <= '0;
         grant1_cnt   <= '0;
         conflict_cnt <= '0;
      end else begin
         if (hs && !win && (grant0_cnt != '1))
            grant0_cnt <= grant0_cnt + CNT_W'(1);
         if (hs && win && (grant1_cnt != '1))
            grant1_cnt <= grant1_cnt + CNT_W'(1);
         if ((state == IDLE) && req0_valid && req1_valid && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
